csr_file: RTL and testbench
===========================

Name: csr_file

Overview:
- Machine-mode CSR register file and trap/return sequencer for the RV32I core.
- Sits directly downstream of the instruction decoder in the execute stage.
- Consumes the decoder's CSR address, CSR immediate, funct3, CSR flag and ECALL/EBREAK/MRET flags.
- Holds trap state; supplies the trap vector and return PC to the PC-select logic.

Parameters:
- MHARTID, 32'h0, value returned by mhartid.
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec (BASE, MODE=direct).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- csr_valid  input  1  CSR instruction in execute this cycle (decoder is_csr qualified by pipeline valid)
- csr_op  input  3  funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI)
- csr_addr  input  12  CSR address
- csr_rs1_data  input  32  rs1 register value
- csr_uimm  input  5  zimm / rs1 index field
- csr_rdata  output  32  old CSR value, written to rd
- csr_illegal  output  1  unimplemented address, or write to a read-only CSR
- trap_entry  input  1  take trap this cycle (ECALL/EBREAK/illegal/misaligned)
- trap_pc  input  32  PC of the faulting instruction
- trap_cause  input  32  mcause value
- trap_val  input  32  mtval value
- mret  input  1  MRET in execute
- instr_retired  input  1  one instruction retired this cycle
- trap_vector  output  32  {mtvec[31:2],2'b00}
- mepc_out  output  32  {mepc[31:1],1'b0}
- mstatus_mie  output  1  global interrupt enable

Behaviour:
- Implemented CSRs:
  - mstatus (0x300; MIE bit3, MPIE bit7, MPP[12:11] hardwired 2'b11; other bits read 0)
  - misa (0x301, RO 32'h4000_0100)
  - mie (0x304), mtvec (0x305), mscratch (0x340), mepc (0x341), mcause (0x342), mtval (0x343)
  - mip (0x344, reads 0, writes ignored)
  - mhartid (0xF14, RO), mvendorid (0xF11, RO 0), marchid (0xF12, RO 0), mimpid (0xF13, RO 0)
- Read path is combinational: csr_rdata = current value of the addressed CSR, or 0 if unimplemented or csr_valid=0.
- Source operand: csr_op[2] ? {27'b0,csr_uimm} : csr_rs1_data.
- New value:
  - RW: src
  - RS: old | src
  - RC: old & ~src
- Write suppression: RS/RC/RSI/RCI with csr_uimm==0 perform no write, and a read-only address is then not illegal.
  - RW/RWI always write, even with rd=0.
- csr_illegal is combinational: csr_valid and (address unimplemented, or address[11:10]==2'b11 and the write is not suppressed). Illegal ops never modify state.
- Updates land at the rising clk edge; the written value is visible to the next cycle's read (no bypass inside the block).
- WARL masking:
  - mtvec[1:0] forced to 00.
  - mepc[1:0] forced to 00.
  - mstatus writes affect only MIE and MPIE.
  - mie writes affect bits 3, 7, 11 only.
- Trap entry (trap_entry=1) at the edge:
  - mepc <= trap_pc & ~3; mcause <= trap_cause; mtval <= trap_val.
  - MPIE <= MIE; MIE <= 0.
- MRET (mret=1, trap_entry=0) at the edge: MIE <= MPIE; MPIE <= 1.
- Priority in one cycle: trap_entry > mret > CSR write.
  - A CSR write coincident with trap_entry or mret is dropped.
  - csr_rdata still reflects the pre-edge value.
- trap_vector and mepc_out are continuous functions of the register state, with no added latency.
- Reset (async, any time, including mid-trap):
  - mstatus MIE=0, MPIE=0; mie, mscratch, mepc, mcause, mtval = 0; mtvec = MTVEC_RESET.
  - Outputs then read: csr_rdata 0 (csr_valid=0), csr_illegal 0, trap_vector MTVEC_RESET, mepc_out 0, mstatus_mie 0.

Optional Feature:
- Macro: CSR_COUNTERS_EN.
- Defined:
  - 64-bit mcycle (0xB00/0xB80 lo/hi) increments every cycle.
  - 64-bit minstret (0xB02/0xB82) increments when instr_retired.
  - Both are writable, with the CSR write taking precedence over the increment in the same cycle.
  - Carry from bit 31 into the high word at wrap (0xFFFF_FFFF -> high+1, low 0).
  - Read-only shadows cycle/instret/cycleh/instreth (0xC00/0xC02/0xC80/0xC82).
  - Reset to 0.
- Undefined: all of these addresses are unimplemented (csr_illegal=1, rdata 0), and instr_retired is ignored.

Test Plan:
- Reset, then CSRRW 0x340 with rs1_data=0xDEAD_BEEF -> rdata 0; next cycle CSRRS 0x340 uimm=0 -> rdata 0xDEAD_BEEF, no write.
- CSRRSI 0x300 uimm=8 -> mstatus_mie=1; then trap_entry with pc=0x100, cause=11 -> mepc=0x100, mcause=11, MIE=0, MPIE=1, trap_vector=mtvec.
- MRET after the previous step -> MIE=1, MPIE=1, mepc_out=0x100; trap_entry and mret asserted together -> trap wins, MIE=0.
- CSRRW 0xF14 -> csr_illegal=1, no state change; CSRRS 0xF14 uimm=0 -> legal, rdata=MHARTID; CSRRW 0x7C0 -> illegal.
- CSRRW 0x305 with 0x8000_0003 -> reads 0x8000_0000; CSRRW 0x341 with 0x1235 -> reads 0x1234.
- With CSR_COUNTERS_EN: write mcycle=0xFFFF_FFFF -> two cycles later mcycleh=1, mcycle=1; without the macro: read 0xB00 -> illegal.

Source files
------------

// File: rtl/csr_file.sv
// rtl/csr_file.sv - machine-mode CSR file with trap entry / MRET sequencing for RV32I
// Optional 64-bit mcycle/minstret counters and their user shadows under `CSR_COUNTERS_EN.
module csr_file #(
  parameter logic [31:0] MHARTID     = 32'h0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_valid,
  input  logic [2:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_rs1_data,
  input  logic [4:0]  csr_uimm,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        trap_entry,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_val,
  input  logic        mret,
  input  logic        instr_retired,
  output logic [31:0] trap_vector,
  output logic [31:0] mepc_out,
  output logic        mstatus_mie
);

  logic        r_mie;
  logic        r_mpie;
  logic [31:0] r_mie_en;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;

  logic        w_impl;
  logic [31:0] w_old;
  logic [31:0] w_src;
  logic [31:0] w_new;
  logic        w_wants_write;
  logic        w_we;
  logic [31:0] w_mstatus;

`ifdef CSR_COUNTERS_EN
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;
`else
  logic        w_unused_retired;
  assign w_unused_retired = instr_retired;
`endif

  assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};

  always_comb begin
    w_impl = 1'b1;
    w_old  = '0;
    case (csr_addr)
      12'h300: w_old = w_mstatus;
      12'h301: w_old = 32'h4000_0100;
      12'h304: w_old = r_mie_en;
      12'h305: w_old = r_mtvec;
      12'h340: w_old = r_mscratch;
      12'h341: w_old = r_mepc;
      12'h342: w_old = r_mcause;
      12'h343: w_old = r_mtval;
      12'h344: w_old = '0;
      12'hF11, 12'hF12, 12'hF13: w_old = '0;
      12'hF14: w_old = MHARTID;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hC00: w_old = r_mcycle[31:0];
      12'hB80, 12'hC80: w_old = r_mcycle[63:32];
      12'hB02, 12'hC02: w_old = r_minstret[31:0];
      12'hB82, 12'hC82: w_old = r_minstret[63:32];
`endif
      default: w_impl = 1'b0;
    endcase
  end

  // Set/clear forms with a zero rs1/uimm field are pure reads.
  assign w_src         = csr_op[2] ? {27'b0, csr_uimm} : csr_rs1_data;
  assign w_wants_write = (csr_op[1:0] == 2'b01) || (csr_op[1] && (csr_uimm != 5'd0));

  always_comb begin
    w_new = w_old;
    case (csr_op[1:0])
      2'b01:   w_new = w_src;
      2'b10:   w_new = w_old | w_src;
      2'b11:   w_new = w_old & ~w_src;
      default: w_new = w_old;
    endcase
  end

  assign csr_illegal = csr_valid &&
                       (!w_impl || ((csr_addr[11:10] == 2'b11) && w_wants_write));
  assign w_we        = csr_valid && w_wants_write && !csr_illegal && !trap_entry && !mret;
  assign csr_rdata   = (csr_valid && w_impl) ? w_old : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_mie_en   <= '0;
      r_mtvec    <= MTVEC_RESET;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
    end else if (trap_entry) begin
      r_mepc   <= trap_pc & ~32'd3;
      r_mcause <= trap_cause;
      r_mtval  <= trap_val;
      r_mpie   <= r_mie;
      r_mie    <= 1'b0;
    end else if (mret) begin
      r_mie  <= r_mpie;
      r_mpie <= 1'b1;
    end else if (w_we) begin
      case (csr_addr)
        12'h300: begin
          r_mie  <= w_new[3];
          r_mpie <= w_new[7];
        end
        12'h304: r_mie_en   <= w_new & 32'h0000_0888;
        12'h305: r_mtvec    <= w_new & ~32'd3;
        12'h340: r_mscratch <= w_new;
        12'h341: r_mepc     <= w_new & ~32'd3;
        12'h342: r_mcause   <= w_new;
        12'h343: r_mtval    <= w_new;
        default: ;
      endcase
    end
  end

`ifdef CSR_COUNTERS_EN
  // A write to either half suppresses that counter's increment for the cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      if (w_we && csr_addr == 12'hB00)      r_mcycle <= {r_mcycle[63:32], w_new};
      else if (w_we && csr_addr == 12'hB80) r_mcycle <= {w_new, r_mcycle[31:0]};
      else                                  r_mcycle <= r_mcycle + 64'd1;

      if (w_we && csr_addr == 12'hB02)      r_minstret <= {r_minstret[63:32], w_new};
      else if (w_we && csr_addr == 12'hB82) r_minstret <= {w_new, r_minstret[31:0]};
      else if (instr_retired)               r_minstret <= r_minstret + 64'd1;
    end
  end
`endif

  assign trap_vector = {r_mtvec[31:2], 2'b00};
  assign mepc_out    = {r_mepc[31:1], 1'b0};
  assign mstatus_mie = r_mie;

endmodule

// File: tb/tb_csr_file.sv
// tb/tb_csr_file.sv - randomized + directed check of csr_file against a behavioural CSR model
module tb_csr_file;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        csr_valid = 1'b0;
  logic [2:0]  csr_op = '0;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_rs1_data = '0;
  logic [4:0]  csr_uimm = '0;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        trap_entry = 1'b0;
  logic [31:0] trap_pc = '0;
  logic [31:0] trap_cause = '0;
  logic [31:0] trap_val = '0;
  logic        mret = 1'b0;
  logic        instr_retired = 1'b0;
  logic [31:0] trap_vector;
  logic [31:0] mepc_out;
  logic        mstatus_mie;

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;

  csr_file dut (
    .clk(clk), .reset(reset), .csr_valid(csr_valid), .csr_op(csr_op),
    .csr_addr(csr_addr), .csr_rs1_data(csr_rs1_data), .csr_uimm(csr_uimm),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .trap_entry(trap_entry),
    .trap_pc(trap_pc), .trap_cause(trap_cause), .trap_val(trap_val), .mret(mret),
    .instr_retired(instr_retired), .trap_vector(trap_vector), .mepc_out(mepc_out),
    .mstatus_mie(mstatus_mie)
  );

  always #5 clk = ~clk;

  // Architectural state of the reference model.
  bit          m_mie, m_mpie;
  logic [31:0] m_mie_en, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cyc, m_ins;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_impl(logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
      12'h344, 12'hF11, 12'hF12, 12'hF13, 12'hF14: return 1'b1;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_val(logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h301: return 32'h4000_0100;
      12'h304: return m_mie_en;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hC00: return m_cyc[31:0];
      12'hB80, 12'hC80: return m_cyc[63:32];
      12'hB02, 12'hC02: return m_ins[31:0];
      12'hB82, 12'hC82: return m_ins[63:32];
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_writes();
    return (csr_op == 3'd1) || (csr_op == 3'd5) || (csr_uimm != 5'd0);
  endfunction

  function automatic bit m_illegal();
    return csr_valid && (!m_impl(csr_addr) || (csr_addr >= 12'hC00 && m_writes()));
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mie = 0; m_mpie = 0; m_mie_en = 0; m_mtvec = 0; m_mscratch = 0;
      m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cyc = 0; m_ins = 0;
    end else begin
      logic [31:0] src, nv;
      bit wr, cw, iw;
      src = (csr_op >= 3'd5) ? 32'(csr_uimm) : csr_rs1_data;
      case (csr_op)
        3'd1, 3'd5: nv = src;
        3'd2, 3'd6: nv = m_val(csr_addr) | src;
        default:    nv = m_val(csr_addr) & ~src;
      endcase
      wr = csr_valid && m_writes() && !m_illegal() && !trap_entry && !mret;
      cw = wr && (csr_addr == 12'hB00 || csr_addr == 12'hB80);
      iw = wr && (csr_addr == 12'hB02 || csr_addr == 12'hB82);
      if (!cw) m_cyc = m_cyc + 1;
      if (!iw && instr_retired) m_ins = m_ins + 1;
      if (trap_entry) begin
        m_mepc = trap_pc & ~32'd3; m_mcause = trap_cause; m_mtval = trap_val;
        m_mpie = m_mie; m_mie = 0;
      end else if (mret) begin
        m_mie = m_mpie; m_mpie = 1;
      end else if (wr) begin
        case (csr_addr)
          12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
          12'h304: m_mie_en = nv & 32'h888;
          12'h305: m_mtvec = nv & ~32'd3;
          12'h340: m_mscratch = nv;
          12'h341: m_mepc = nv & ~32'd3;
          12'h342: m_mcause = nv;
          12'h343: m_mtval = nv;
          12'hB00: m_cyc[31:0] = nv;
          12'hB80: m_cyc[63:32] = nv;
          12'hB02: m_ins[31:0] = nv;
          12'hB82: m_ins[63:32] = nv;
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rdata", csr_rdata, (csr_valid && m_impl(csr_addr)) ? m_val(csr_addr) : 32'h0);
      chk("illegal", 32'(csr_illegal), 32'(m_illegal()));
      chk("trap_vector", trap_vector, m_mtvec);
      chk("mepc_out", mepc_out, m_mepc & ~32'd1);
      chk("mstatus_mie", 32'(mstatus_mie), 32'(m_mie));
    end
  end

  task automatic drive(bit v, logic [2:0] op, logic [11:0] a, logic [31:0] rs1,
                       logic [4:0] u, bit t, bit m);
    @(posedge clk);
    #1;
    csr_valid = v; csr_op = op; csr_addr = a; csr_rs1_data = rs1;
    csr_uimm = u; trap_entry = t; mret = m;
  endtask

  logic [11:0] addrs [24] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                              12'h342, 12'h343, 12'h344, 12'hF11, 12'hF12, 12'hF13,
                              12'hF14, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00,
                              12'hC02, 12'hC80, 12'hC82, 12'h7C0, 12'h123, 12'h305};
  logic [2:0]  ops [6] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_rdata", csr_rdata, 32'h0);
    chk("rst_illegal", 32'(csr_illegal), 32'h0);
    chk("rst_tvec", trap_vector, 32'h0);
    chk("rst_mepc", mepc_out, 32'h0);
    chk("rst_mie", 32'(mstatus_mie), 32'h0);

    drive(1, 3'd1, 12'h340, 32'hDEAD_BEEF, 0, 0, 0); @(negedge clk);
    chk("rw_scratch_old", csr_rdata, 32'h0);
    drive(1, 3'd2, 12'h340, 32'hFFFF_FFFF, 0, 0, 0); @(negedge clk);
    chk("rs_scratch", csr_rdata, 32'hDEAD_BEEF);
    drive(1, 3'd2, 12'h340, 32'hFFFF_FFFF, 0, 0, 0); @(negedge clk);
    chk("rs0_nowrite", csr_rdata, 32'hDEAD_BEEF);
    drive(1, 3'd6, 12'h300, 0, 5'd8, 0, 0);
    drive(0, 3'd0, 12'h0, 0, 0, 0, 0); @(negedge clk);
    chk("rsi_mie", 32'(mstatus_mie), 32'h1);

    trap_pc = 32'h100; trap_cause = 32'd11; trap_val = 32'h55;
    drive(0, 3'd0, 12'h0, 0, 0, 1, 0);
    drive(1, 3'd2, 12'h341, 0, 0, 0, 0); @(negedge clk);
    chk("trap_mepc", csr_rdata, 32'h100);
    chk("trap_mie", 32'(mstatus_mie), 32'h0);
    drive(1, 3'd2, 12'h342, 0, 0, 0, 0); @(negedge clk);
    chk("trap_mcause", csr_rdata, 32'd11);
    drive(1, 3'd2, 12'h300, 0, 0, 0, 0); @(negedge clk);
    chk("trap_mstatus", csr_rdata, 32'h1880);
    chk("trap_vec", trap_vector, 32'h0);

    drive(0, 3'd0, 12'h0, 0, 0, 0, 1);
    drive(1, 3'd2, 12'h300, 0, 0, 0, 0); @(negedge clk);
    chk("mret_mstatus", csr_rdata, 32'h1888);
    chk("mret_mie", 32'(mstatus_mie), 32'h1);
    chk("mret_mepc", mepc_out, 32'h100);

    trap_pc = 32'h203;
    drive(1, 3'd1, 12'h340, 32'h1, 0, 1, 1);
    drive(1, 3'd2, 12'h300, 0, 0, 0, 0); @(negedge clk);
    chk("trap_over_mret_mie", 32'(mstatus_mie), 32'h0);
    chk("trap_over_mret_st", csr_rdata, 32'h1880);
    chk("trap_over_mret_pc", mepc_out, 32'h200);
    drive(1, 3'd2, 12'h340, 0, 0, 0, 0); @(negedge clk);
    chk("trap_drops_write", csr_rdata, 32'hDEAD_BEEF);

    drive(1, 3'd1, 12'hF14, 32'h123, 0, 0, 0); @(negedge clk);
    chk("rw_hartid_ill", 32'(csr_illegal), 32'h1);
    drive(1, 3'd2, 12'hF14, 0, 0, 0, 0); @(negedge clk);
    chk("rs_hartid_legal", 32'(csr_illegal), 32'h0);
    chk("hartid", csr_rdata, 32'h0);
    drive(1, 3'd1, 12'h7C0, 32'h1, 0, 0, 0); @(negedge clk);
    chk("unimpl_ill", 32'(csr_illegal), 32'h1);

    drive(1, 3'd1, 12'h305, 32'h8000_0003, 0, 0, 0);
    drive(1, 3'd2, 12'h305, 0, 0, 0, 0); @(negedge clk);
    chk("mtvec_warl", csr_rdata, 32'h8000_0000);
    chk("tvec_out", trap_vector, 32'h8000_0000);
    drive(1, 3'd1, 12'h341, 32'h1235, 0, 0, 0);
    drive(1, 3'd2, 12'h341, 0, 0, 0, 0); @(negedge clk);
    chk("mepc_warl", csr_rdata, 32'h1234);

`ifdef CSR_COUNTERS_EN
    drive(1, 3'd1, 12'hB00, 32'hFFFF_FFFF, 0, 0, 0);
    drive(0, 3'd0, 12'h0, 0, 0, 0, 0);
    drive(0, 3'd0, 12'h0, 0, 0, 0, 0);
    drive(1, 3'd2, 12'hB00, 0, 0, 0, 0); @(negedge clk);
    chk("mcycle_wrap_lo", csr_rdata, 32'h1);
    drive(1, 3'd2, 12'hB80, 0, 0, 0, 0); @(negedge clk);
    chk("mcycle_wrap_hi", csr_rdata, 32'h1);
`else
    drive(1, 3'd2, 12'hB00, 0, 0, 0, 0); @(negedge clk);
    chk("no_counter_ill", 32'(csr_illegal), 32'h1);
    chk("no_counter_rd", csr_rdata, 32'h0);
`endif

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      csr_valid = ($urandom_range(0, 3) != 0);
      csr_op = ops[$urandom_range(0, 5)];
      csr_addr = addrs[$urandom_range(0, 23)];
      csr_rs1_data = $urandom;
      csr_uimm = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      trap_entry = ($urandom_range(0, 15) == 0);
      mret = ($urandom_range(0, 15) == 0);
      trap_pc = $urandom; trap_cause = $urandom; trap_val = $urandom;
      instr_retired = $urandom_range(0, 1) == 1;
    end

    drive(0, 3'd0, 12'h0, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    trap_entry = 1'b0;
    @(negedge clk);
    chk("midrst_rdata", csr_rdata, 32'h0);
    chk("midrst_illegal", 32'(csr_illegal), 32'h0);
    chk("midrst_tvec", trap_vector, 32'h0);
    chk("midrst_mepc", mepc_out, 32'h0);
    chk("midrst_mie", 32'(mstatus_mie), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1, 3'd2, 12'h340, 0, 0, 0, 0); @(negedge clk);
    chk("midrst_scratch", csr_rdata, 32'h0);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
